// File: rtl/manch_pkg.sv
// Shared types, default sizing and the symbol helper for the Manchester transmitter.
// Pure declarations: no latency and no flow control of its own.
// Bit encoding is IEEE 802.3 style: first half-bit is ~b, second half-bit is b.
package manch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        GAP
    } tx_state_t;

    localparam int DATAWIDTH        = 8;
    localparam int counter_max      = 20;
    localparam int half_counter_max = 10;
    localparam int IDLE_GAP         = 20;

    function automatic logic manch_sym(input logic b, input logic phase);
        return phase ? b : ~b;
    endfunction

endpackage

// File: rtl/manch_bit_timer.sv
// Half-bit counter plus phase flag; half_tick on every half-bit wrap, bit_tick on each full bit.
// Ticks are combinational from the counter flops, so they are valid in the cycle before the boundary edge.
// No backpressure: it free-runs while en is high and is held cleared while en is low.
module manch_bit_timer #(
    parameter int half_counter_max = manch_pkg::half_counter_max
) (
    input  logic clk_20x,
    input  logic rst_n,
    input  logic en,
    output logic half_tick,
    output logic bit_tick,
    output logic phase
);

    localparam int CW = (half_counter_max > 1) ? $clog2(half_counter_max) : 1;

    logic [CW-1:0] half_cnt;
    logic          wrap;

    assign wrap      = (half_cnt == CW'(half_counter_max - 1));
    assign half_tick = en & wrap;
    assign bit_tick  = half_tick & phase;

    always_ff @(posedge clk_20x or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt <= '0;
            phase    <= 1'b0;
        end else if (!en) begin
            half_cnt <= '0;
            phase    <= 1'b0;
        end else if (wrap) begin
            half_cnt <= '0;
            phase    <= ~phase;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/manch_encoder_tx.sv
// Manchester transmitter: start symbol, DATAWIDTH bits LSB-first, optional parity (MANCH_TX_PARITY_EN), idle gap.
// Latency: word captured on the accepting edge; the line goes high on that same edge (first start half-bit).
// Backpressure: ready is low for the whole frame plus IDLE_GAP cycles; load while ready=0 is ignored.
module manch_encoder_tx
    import manch_pkg::*;
#(
    parameter int DATAWIDTH        = manch_pkg::DATAWIDTH,
    parameter int counter_max      = manch_pkg::counter_max,
    parameter int half_counter_max = manch_pkg::half_counter_max,
    parameter int IDLE_GAP         = manch_pkg::IDLE_GAP
) (
    input  logic                 clk_20x,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] parallel_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 manch_encode_output,
    output logic                 busy,
    output logic                 flag
);

    localparam int IW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam int GW = $clog2(IDLE_GAP + 1);

    tx_state_t            state;
    logic [DATAWIDTH-1:0] shift_reg;
    logic [IW-1:0]        bit_idx;
    logic [GW-1:0]        gap_cnt;
    logic                 timer_en;
    logic                 half_tick;
    logic                 bit_tick;
    logic                 phase;
`ifdef MANCH_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign busy     = ~ready;
    assign timer_en = (state == START) || (state == DATA) || (state == PARITY);

    manch_bit_timer #(
        .half_counter_max(half_counter_max)
    ) u_bit_timer (
        .clk_20x  (clk_20x),
        .rst_n    (rst_n),
        .en       (timer_en),
        .half_tick(half_tick),
        .bit_tick (bit_tick),
        .phase    (phase)
    );

    always_ff @(posedge clk_20x or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            shift_reg           <= '0;
            bit_idx             <= '0;
            gap_cnt             <= '0;
            manch_encode_output <= 1'b0;
            ready               <= 1'b1;
            flag                <= 1'b0;
`ifdef MANCH_TX_PARITY_EN
            parity_bit          <= 1'b0;
`endif
        end else begin
            flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (load && ready) begin
                        state               <= START;
                        shift_reg           <= parallel_in;
                        bit_idx             <= '0;
                        ready               <= 1'b0;
                        manch_encode_output <= manch_sym(1'b0, 1'b0);
`ifdef MANCH_TX_PARITY_EN
                        parity_bit          <= ^parallel_in;
`endif
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state               <= DATA;
                        manch_encode_output <= manch_sym(shift_reg[0], 1'b0);
                    end else if (half_tick) begin
                        manch_encode_output <= manch_sym(1'b0, 1'b1);
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == IW'(DATAWIDTH - 1)) begin
`ifdef MANCH_TX_PARITY_EN
                            state               <= PARITY;
                            manch_encode_output <= manch_sym(parity_bit, 1'b0);
`else
                            state               <= GAP;
                            gap_cnt             <= '0;
                            flag                <= 1'b1;
                            manch_encode_output <= 1'b0;
`endif
                        end else begin
                            // shift_reg[1] becomes the new LSB on this edge
                            bit_idx             <= bit_idx + 1'b1;
                            shift_reg           <= shift_reg >> 1;
                            manch_encode_output <= manch_sym(shift_reg[1], 1'b0);
                        end
                    end else if (half_tick) begin
                        manch_encode_output <= manch_sym(shift_reg[0], 1'b1);
                    end
                end
`ifdef MANCH_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        state               <= GAP;
                        gap_cnt             <= '0;
                        flag                <= 1'b1;
                        manch_encode_output <= 1'b0;
                    end else if (half_tick) begin
                        manch_encode_output <= manch_sym(parity_bit, 1'b1);
                    end
                end
`endif
                GAP: begin
                    if (gap_cnt == GW'(IDLE_GAP - 1)) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                        ready   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state               <= IDLE;
                    ready               <= 1'b1;
                    manch_encode_output <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manch_encoder_tx.sv
// Randomized bench for manch_encoder_tx: per-cycle line/flag/ready against a symbol-arithmetic model,
// plus a bench-side decoder that recovers the payload from the line.
module tb_manch_encoder_tx;

`ifdef MANCH_TX_PARITY_EN
    localparam int NSYM = 10;
`else
    localparam int NSYM = 9;
`endif
    localparam int BITC  = 20;
    localparam int LINEC = NSYM * BITC;
    localparam int GAPC  = 20;

    logic       clk_20x = 1'b0;
    logic       rst_n;
    logic [7:0] parallel_in;
    logic       load;
    logic       ready;
    logic       manch_encode_output;
    logic       busy;
    logic       flag;

    int errors = 0;
    int checks = 0;

    always #5 clk_20x = ~clk_20x;

    manch_encoder_tx dut (
        .clk_20x            (clk_20x),
        .rst_n              (rst_n),
        .parallel_in        (parallel_in),
        .load               (load),
        .ready              (ready),
        .manch_encode_output(manch_encode_output),
        .busy               (busy),
        .flag               (flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Line level k cycles after the accepting edge: symbol k/20, half (k%20)/10.
    function automatic logic exp_line(input logic [7:0] w, input int k);
        int   sym;
        logic b;
        if (k >= LINEC) return 1'b0;
        sym = k / BITC;
        if (sym == 0)      b = 1'b0;
        else if (sym <= 8) b = w[sym-1];
        else               b = ^w;
        return ((k % BITC) >= (BITC / 2)) ? b : ~b;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk_20x);
        while (!ready && n < 1000) begin
            @(negedge clk_20x);
            n++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    // preloaded: load is already high and the next edge accepts; hold: keep load high afterwards.
    task automatic run_frame(input logic [7:0] word, input logic preloaded, input logic [7:0] next_word,
                             input logic hold, input logic poke);
        logic [7:0] dec = '0;
        int line_bad = 0, flag_bad = 0, rdy_bad = 0;
        if (!preloaded) begin
            wait_ready();
            parallel_in = word;
            load        = 1'b1;
        end
        @(posedge clk_20x);
        #1;
        parallel_in = next_word;
        if (!hold) load = 1'b0;
        for (int k = 0; k <= LINEC + GAPC; k++) begin
            @(negedge clk_20x);
            if (manch_encode_output !== exp_line(word, k)) begin
                if (line_bad == 0) chk($sformatf("line[%0d] w=%0h", k, word),
                                       32'(manch_encode_output), 32'(exp_line(word, k)));
                line_bad++;
            end
            if (flag !== (k == LINEC)) begin
                if (flag_bad == 0) chk($sformatf("flag[%0d]", k), 32'(flag), 32'(k == LINEC));
                flag_bad++;
            end
            if (ready !== (k == LINEC + GAPC) || busy !== ~ready) begin
                if (rdy_bad == 0) chk($sformatf("ready_busy[%0d]", k), {30'd0, busy, ready},
                                      {30'd0, k != LINEC + GAPC, k == LINEC + GAPC});
                rdy_bad++;
            end
            if (k >= BITC && k < 9 * BITC && (k % BITC) == 15) dec[(k / BITC) - 1] = manch_encode_output;
            if (poke && k == 60) begin
                load        = 1'b1;
                parallel_in = 8'h3C;
            end
            if (poke && k == 62) load = 1'b0;
        end
        if (line_bad == 0) chk("line_ok", 32'd0, 32'd0 + 32'(line_bad));
        if (flag_bad == 0) chk("flag_ok", 32'(flag_bad), 32'd0);
        if (rdy_bad == 0)  chk("ready_ok", 32'(rdy_bad), 32'd0);
        chk($sformatf("decoded w=%0h", word), 32'(dec), 32'(word));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] sweep[$];
        int act;

        rst_n       = 1'b0;
        load        = 1'b0;
        parallel_in = 8'h00;
        repeat (3) @(posedge clk_20x);
        @(negedge clk_20x);
        chk("rst_out",   32'(manch_encode_output), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_flag",  32'(flag), 32'd0);
        rst_n = 1'b1;
        act   = 0;
        repeat (30) begin
            @(negedge clk_20x);
            if (manch_encode_output !== 1'b0 || ready !== 1'b1 || flag !== 1'b0) act++;
        end
        chk("idle_quiet", 32'(act), 32'd0);

        // A5 with a late load of 3C poked mid-frame, and parallel_in changed after acceptance
        run_frame(8'hA5, 1'b0, 8'h3C, 1'b0, 1'b1);
        act = 0;
        repeat (40) begin
            @(negedge clk_20x);
            if (manch_encode_output !== 1'b0 || ready !== 1'b1) act++;
        end
        chk("no_second_frame", 32'(act), 32'd0);

        // Held load: 00 then FF back-to-back, the second accepted on the first ready cycle
        run_frame(8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_frame(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of a frame
        wait_ready();
        parallel_in = 8'hC3;
        load        = 1'b1;
        @(posedge clk_20x);
        #1;
        load = 1'b0;
        repeat (94) @(negedge clk_20x);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out",   32'(manch_encode_output), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        repeat (2) @(negedge clk_20x);
        rst_n = 1'b1;
        @(posedge clk_20x);
        @(negedge clk_20x);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_out",   32'(manch_encode_output), 32'd0);
        run_frame(8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);

        sweep = '{8'h00, 8'hFF, 8'h55, 8'hAA};
        for (int i = 0; i < 16; i++) sweep.push_back(8'($urandom_range(0, 255)));
        foreach (sweep[i]) run_frame(sweep[i], 1'b0, 8'($urandom), 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
